dkong_scandoubler: RTL and testbench

- Consumer end of the video pixel stream that the video generator produces (video_valid, 3/3/2 RGB, blank timing).
- Captures each 15 kHz arcade line into a ping-pong line buffer.
- Replays each captured line twice at double line rate, with regenerated sync, for a 31 kHz VGA-class monitor.
- Sits between the video generator and the board's VGA DAC pins.

---
 rtl/dkong_scandoubler.sv | 199 +++++++++++++++++++
 tb/tb_dkong_scandoubler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dkong_scandoubler.sv
// dkong_scandoubler
//   Converts the 15 kHz arcade pixel stream into a 31 kHz VGA-class stream.
//   Each input line is captured into one bank of a ping-pong line buffer while
//   the other bank is replayed twice at double line rate with regenerated sync.
//
// Ports
//   clk                     system clock (shared with the video generator)
//   rst                     synchronous reset, active-high
//   in_valid                one-cycle pixel strobe
//   in_r/in_g/in_b          3/3/2 input pixel
//   in_hblank / in_vblank   input blanking; hblank rising edge ends a line
//   out_r/out_g/out_b       3/3/2 output pixel, forced to 0 when out_de=0
//   out_de                  output display enable
//   out_hs_n / out_vs_n     regenerated sync, active low
module dkong_scandoubler #(
    parameter int H_ACTIVE   = 256,
    parameter int PIX_DIV    = 5,
    parameter int OUT_HTOTAL = 1920,
    parameter int HS_START   = 1344,
    parameter int HS_LEN     = 192,
    parameter int VS_LINES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_r,
    input  logic [2:0] in_g,
    input  logic [1:0] in_b,
    input  logic       in_hblank,
    input  logic       in_vblank,
    output logic [2:0] out_r,
    output logic [2:0] out_g,
    output logic [1:0] out_b,
    output logic       out_de,
    output logic       out_hs_n,
    output logic       out_vs_n
);

    localparam int AW = $clog2(H_ACTIVE);          // buffer address within a bank
    localparam int XW = $clog2(H_ACTIVE + 1);      // pixel count, holds H_ACTIVE
    localparam int HW = $clog2(OUT_HTOTAL);        // output line counter
    localparam int SW = $clog2(PIX_DIV + 1);       // pixel sub-counter
    localparam int LW = $clog2(VS_LINES + 1);      // vsync line counter

    localparam logic [XW-1:0] X_FULL    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_ONE     = XW'(1);
    localparam logic [HW-1:0] H_LAST    = HW'(OUT_HTOTAL - 1);
    localparam logic [HW-1:0] H_ONE     = HW'(1);
    localparam logic [HW-1:0] ACT_END   = HW'(H_ACTIVE * PIX_DIV);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(HS_START);
    localparam logic [HW-1:0] HS_END    = HW'(HS_START + HS_LEN);
    localparam logic [SW-1:0] SUB_LAST  = SW'(PIX_DIV - 1);
    localparam logic [SW-1:0] SUB_ONE   = SW'(1);
    localparam logic [LW-1:0] LINE_FULL = LW'(VS_LINES);
    localparam logic [LW-1:0] LINE_LAST = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] LINE_ONE  = LW'(1);

    // Line buffer: bank select is the MSB of the address.
    logic [7:0]    r_mem [2*H_ACTIVE];
    logic [7:0]    r_rd_data;

    // Write side
    logic          r_hblank_q;
    logic          r_locked;       // set by the first hblank edge after reset
    logic          r_wr_bank;
    logic [XW-1:0] r_wr_x;
    logic [XW-1:0] r_len [2];

    // Read side. The two replay passes are indistinguishable (same bank,
    // same data), so no pass index is kept.
    logic [HW-1:0] r_out_hcnt;
    logic [SW-1:0] r_sub;
    logic [XW-1:0] r_rd_x;
    logic          r_vblank_q;
    logic [LW-1:0] r_out_line;
    logic          r_vs_active;

    // Stage-1 control, aligned with r_rd_data
    logic          r_s1_de;
    logic          r_s1_mask;
    logic          r_s1_hs_n;
    logic          r_s1_vs_n;

    logic          w_hb_edge;
    logic          w_accept;
    logic          w_line_end;
    logic          w_active;
    logic          w_hs_n;
    logic          w_rd_bank;

    assign w_hb_edge  = in_hblank & ~r_hblank_q;
    // in_hblank=0 here, so an accepted pixel can never coincide with an edge.
    assign w_accept   = r_locked & in_valid & ~in_hblank & (r_wr_x != X_FULL);
    assign w_line_end = (r_out_hcnt == H_LAST);
    assign w_active   = r_locked & ~r_vblank_q & (r_out_hcnt < ACT_END);
    assign w_hs_n     = ~((r_out_hcnt >= HS_BEGIN) && (r_out_hcnt < HS_END));
    assign w_rd_bank  = ~r_wr_bank;

    // NOTE: the line buffer has no reset so it maps onto block RAM; stale
    // contents never reach the output because reads past the stored length
    // are masked to black.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, r_wr_x[AW-1:0]}] <= {in_r, in_g, in_b};
        end
        r_rd_data <= r_mem[{w_rd_bank, r_rd_x[AW-1:0]}];
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to 1 so that a reset held during hblank does not fake an edge.
            r_hblank_q  <= 1'b1;
            r_locked    <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_x      <= '0;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
            r_out_hcnt  <= '0;
            r_sub       <= '0;
            r_rd_x      <= '0;
            r_vblank_q  <= 1'b0;
            r_out_line  <= '0;
            r_vs_active <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_mask   <= 1'b1;
            r_s1_hs_n   <= 1'b1;
            r_s1_vs_n   <= 1'b1;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
            out_de      <= 1'b0;
            out_hs_n    <= 1'b1;
            out_vs_n    <= 1'b1;
        end else begin
            r_hblank_q <= in_hblank;

            // Write side: an hblank edge closes the line and swaps banks.
            if (w_hb_edge) begin
                r_len[r_wr_bank] <= r_wr_x;
                r_wr_x           <= '0;
                r_wr_bank        <= ~r_wr_bank;
                r_locked         <= 1'b1;
                r_vblank_q       <= in_vblank;
            end else if (w_accept) begin
                r_wr_x <= r_wr_x + X_ONE;
            end

            // Read timing: the hblank edge phase-locks the output line,
            // otherwise the counters free-run.
            if (w_hb_edge || w_line_end) begin
                r_out_hcnt <= '0;
                r_sub      <= '0;
                r_rd_x     <= '0;
            end else begin
                r_out_hcnt <= r_out_hcnt + H_ONE;
                if (r_sub == SUB_LAST) begin
                    r_sub <= '0;
                    if (r_rd_x != X_FULL) begin
                        r_rd_x <= r_rd_x + X_ONE;
                    end
                end else begin
                    r_sub <= r_sub + SUB_ONE;
                end
            end

            // Vsync: started by the vblank rising edge, lasts VS_LINES output
            // lines. An hblank edge also ends an output line, so a lock edge
            // landing on a natural wrap is still counted once.
            if (w_hb_edge && in_vblank && !r_vblank_q) begin
                r_out_line  <= '0;
                r_vs_active <= 1'b1;
            end else if ((w_hb_edge || w_line_end) && (r_out_line != LINE_FULL)) begin
                r_out_line <= r_out_line + LINE_ONE;
                if (r_out_line == LINE_LAST) begin
                    r_vs_active <= 1'b0;
                end
            end

            // Stage 1: buffer read in flight, control follows alongside.
            r_s1_de   <= w_active;
            r_s1_mask <= (r_rd_x >= r_len[w_rd_bank]);
            r_s1_hs_n <= w_hs_n;
            r_s1_vs_n <= ~r_vs_active;

            // Stage 2: output register with masking and colour gating.
            out_de   <= r_s1_de;
            out_hs_n <= r_s1_hs_n;
            out_vs_n <= r_s1_vs_n;
            if (r_s1_de && !r_s1_mask) begin
                {out_r, out_g, out_b} <= r_rd_data;
            end else begin
                {out_r, out_g, out_b} <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_dkong_scandoubler.sv
// tb_dkong_scandoubler
//   Directed bench for dkong_scandoubler: captures hand-built lines, then
//   scans the replayed output cycle by cycle against expected timing/pixels.
module tb_dkong_scandoubler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_r = '0;
    logic [2:0] in_g = '0;
    logic [1:0] in_b = '0;
    logic       in_hblank = 1'b0;
    logic       in_vblank = 1'b0;
    logic [2:0] out_r;
    logic [2:0] out_g;
    logic [1:0] out_b;
    logic       out_de;
    logic       out_hs_n;
    logic       out_vs_n;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_line [256];
    int         exp_len = 0;

    dkong_scandoubler dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_r     (in_r),
        .in_g     (in_g),
        .in_b     (in_b),
        .in_hblank(in_hblank),
        .in_vblank(in_vblank),
        .out_r    (out_r),
        .out_g    (out_g),
        .out_b    (out_b),
        .out_de   (out_de),
        .out_hs_n (out_hs_n),
        .out_vs_n (out_vs_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_scan(input string tag, input int bad, input int k,
                              input logic [7:0] o, input logic [7:0] e);
        n_cmp++;
        assert (bad == 0) else begin
            n_fail++;
            $error("FAIL %s: %0d bad cycles, first at cycle %0d observed 0x%0h expected 0x%0h",
                   tag, bad, k, o, e);
        end
    endtask

    // Writes n pixels (value base+x; pixels past 256 get inverted values so a
    // missed saturation would corrupt the line), then raises hblank.
    task automatic send_line(input int n, input logic [7:0] base, input bit coincident);
        logic [7:0] v;
        in_hblank = 1'b0;
        in_valid  = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            v = 8'(i) + base;
            if (i >= 256) v = ~v;
            else exp_line[i] = v;
            {in_r, in_g, in_b} = v;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        exp_len  = (n < 256) ? n : 256;
        in_hblank = 1'b1;
        if (coincident) begin
            in_valid = 1'b1;
            {in_r, in_g, in_b} = 8'hEE;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the hblank edge. Output at cycle k reflects
    // out_hcnt = k-2 of the current 1920-cycle output line.
    task automatic scan(input string tag, input int n, input bit vb, input int vs_lines);
        int bad [4];
        int fk [4];
        logic [7:0] fo [4];
        logic [7:0] fe [4];
        logic [7:0] o [4];
        logic [7:0] e [4];
        int h, ln, x;
        for (int j = 0; j < 4; j++) begin
            bad[j] = 0; fk[j] = 0; fo[j] = '0; fe[j] = '0;
        end
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k < 2) continue;
            h  = (k - 2) % 1920;
            ln = (k - 2) / 1920;
            x  = h / 5;
            e[0] = {7'd0, (!vb && h < 1280)};
            e[1] = (e[0][0] && x < exp_len) ? exp_line[x] : 8'h00;
            e[2] = {7'd0, !(h >= 1344 && h < 1536)};
            e[3] = {7'd0, !(ln < vs_lines)};
            o[0] = {7'd0, out_de};
            o[1] = {out_r, out_g, out_b};
            o[2] = {7'd0, out_hs_n};
            o[3] = {7'd0, out_vs_n};
            for (int j = 0; j < 4; j++) begin
                if (o[j] !== e[j]) begin
                    if (bad[j] == 0) begin
                        fk[j] = k; fo[j] = o[j]; fe[j] = e[j];
                    end
                    bad[j]++;
                end
            end
        end
        check_scan({tag, "_de"},  bad[0], fk[0], fo[0], fe[0]);
        check_scan({tag, "_rgb"}, bad[1], fk[1], fo[1], fe[1]);
        check_scan({tag, "_hs"},  bad[2], fk[2], fo[2], fe[2]);
        check_scan({tag, "_vs"},  bad[3], fk[3], fo[3], fe[3]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_de"},  {31'd0, out_de}, 32'd0);
        check({tag, "_rgb"}, {24'd0, out_r, out_g, out_b}, 32'd0);
        check({tag, "_hs"},  {31'd0, out_hs_n}, 32'd1);
        check({tag, "_vs"},  {31'd0, out_vs_n}, 32'd1);
    endtask

    initial begin
        int bad_de;
        int first_k;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full 256-pixel line, replayed on two consecutive output lines
        send_line(0, 8'h00, 1'b0);        // lock edge
        send_line(256, 8'h00, 1'b0);
        scan("full", 3842, 1'b0, 0);

        // Short line: pixels past the stored length show black
        send_line(100, 8'h40, 1'b0);
        scan("short", 1922, 1'b0, 0);

        // Overlong line: only the first 256 pixels are kept
        send_line(300, 8'h33, 1'b0);
        scan("long", 1922, 1'b0, 0);

        // Pixel strobe coinciding with the hblank edge is dropped
        send_line(10, 8'h80, 1'b1);
        scan("coinc", 1922, 1'b0, 0);
        send_line(5, 8'h11, 1'b0);
        scan("coinc_next", 1922, 1'b0, 0);

        // Vertical blank: 4 lines of vsync, no display, hsync keeps running
        in_vblank = 1'b1;
        send_line(0, 8'h00, 1'b0);
        scan("vblank", 5 * 1920 + 2, 1'b1, 4);
        send_line(0, 8'h00, 1'b0);        // vblank still high: no retrigger
        scan("vb_hold", 1922, 1'b1, 0);
        in_vblank = 1'b0;
        send_line(50, 8'h20, 1'b0);
        scan("vb_end", 1922, 1'b0, 0);

        // Reset mid-line while pixels are being displayed
        send_line(256, 8'h60, 1'b0);
        repeat (100) tick();              // output now at out_hcnt = 98
        check("pre_rst_de",  {31'd0, out_de}, 32'd1);
        check("pre_rst_rgb", {24'd0, out_r, out_g, out_b}, {24'd0, exp_line[19]});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        bad_de  = 0;
        first_k = 0;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            if (out_de !== 1'b0) begin
                if (bad_de == 0) first_k = k;
                bad_de++;
            end
        end
        check_scan("post_rst_de", bad_de, first_k, {7'd0, out_de}, 8'h00);
        send_line(0, 8'h00, 1'b0);        // relock
        send_line(40, 8'h05, 1'b0);
        scan("recover", 1922, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
